// File: rtl/csi_tx_packetizer.sv
// CSI-2 transmit packetizer for a 2-lane D-PHY link: sync, header+ECC, payload, CRC footer, trail.
// Optional macro CSI_TX_CRC_EN: when defined the footer carries the CRC-16, otherwise it is fixed at 0x0000.
module csi_tx_packetizer #(
    parameter int PREP_CYC  = 4,
    parameter int TRAIL_CYC = 2,
    parameter int GAP_CYC   = 8
) (
    input  logic        byte_clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_vc,
    input  logic [5:0]  cmd_dt,
    input  logic [15:0] cmd_wc,
    input  logic [15:0] pix_dat,
    input  logic        pix_vld,
    output logic        pix_rdy,
    output logic        hs_req,
    output logic [15:0] tx_dat,
    output logic        tx_vld,
    output logic        err_underflow,
    output logic        err_wc
);

    typedef enum logic [3:0] {IDLE, PREP, SYNC, HDR0, HDR1, PAYLOAD, CRC, TRAIL, GAP} state_t;

    // The accept cycle already counts as the first PREP cycle on the wire, hence the -2.
    localparam logic [14:0] PREP_LOAD  = 15'((PREP_CYC > 1) ? (PREP_CYC - 2) : 0);
    localparam logic [14:0] TRAIL_LOAD = 15'(TRAIL_CYC - 1);
    localparam logic [14:0] GAP_SHORT  = 15'(GAP_CYC - 1);
    localparam logic [14:0] GAP_FULL   = 15'(GAP_CYC);

    state_t      state_reg;
    logic [14:0] cnt_reg;
    logic [7:0]  di_reg;
    logic [15:0] wc_reg;
    logic [15:0] crc_reg;
    logic [15:0] pix_word;

    assign pix_rdy  = (state_reg == PAYLOAD);
    assign pix_word = pix_vld ? pix_dat : 16'h0000;

    // Row masks of the CSI-2 header Hamming code; bit 0 of d is D0.
    function automatic logic [7:0] hdr_ecc(input logic [23:0] d);
        hdr_ecc = {2'b00,
                   ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
                   ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
    endfunction

`ifdef CSI_TX_CRC_EN
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 16'h8408;
            else             r = r >> 1;
        end
        return r;
    endfunction
`endif

    always_ff @(posedge byte_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            di_reg        <= '0;
            wc_reg        <= '0;
            crc_reg       <= 16'hFFFF;
            cmd_ready     <= 1'b0;
            hs_req        <= 1'b0;
            tx_dat        <= '0;
            tx_vld        <= 1'b0;
            err_underflow <= 1'b0;
            err_wc        <= 1'b0;
        end else begin
            cmd_ready <= 1'b0;
            hs_req    <= 1'b0;
            tx_vld    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tx_dat  <= '0;
                    crc_reg <= 16'hFFFF;
                    if (cmd_valid && cmd_ready) begin
                        di_reg <= {cmd_vc, cmd_dt};
                        wc_reg <= cmd_wc;
                        if (cmd_dt >= 6'h10 && cmd_wc[0]) begin
                            err_wc    <= 1'b1;
                            state_reg <= GAP;
                            cnt_reg   <= GAP_SHORT;
                        end else begin
                            hs_req <= 1'b1;
                            if (PREP_CYC > 1) begin
                                state_reg <= PREP;
                                cnt_reg   <= PREP_LOAD;
                            end else begin
                                state_reg <= SYNC;
                            end
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                PREP: begin
                    hs_req <= 1'b1;
                    if (cnt_reg == '0) state_reg <= SYNC;
                    else               cnt_reg   <= cnt_reg - 15'd1;
                end
                SYNC: begin
                    hs_req    <= 1'b1;
                    tx_vld    <= 1'b1;
                    tx_dat    <= 16'hB8B8;
                    state_reg <= HDR0;
                end
                HDR0: begin
                    hs_req    <= 1'b1;
                    tx_vld    <= 1'b1;
                    tx_dat    <= {wc_reg[7:0], di_reg};
                    state_reg <= HDR1;
                end
                HDR1: begin
                    hs_req <= 1'b1;
                    tx_vld <= 1'b1;
                    tx_dat <= {hdr_ecc({wc_reg, di_reg}), wc_reg[15:8]};
                    if (di_reg[5:0] < 6'h10) begin
                        state_reg <= TRAIL;
                        cnt_reg   <= TRAIL_LOAD;
                    end else if (wc_reg == 16'h0000) begin
                        state_reg <= CRC;
                    end else begin
                        state_reg <= PAYLOAD;
                        cnt_reg   <= wc_reg[15:1] - 15'd1;
                    end
                end
                PAYLOAD: begin
                    // A missing word goes out as zero and still counts: the burst never stalls.
                    hs_req <= 1'b1;
                    tx_vld <= 1'b1;
                    tx_dat <= pix_word;
                    if (!pix_vld) err_underflow <= 1'b1;
`ifdef CSI_TX_CRC_EN
                    crc_reg <= crc_byte(crc_byte(crc_reg, pix_word[7:0]), pix_word[15:8]);
`endif
                    if (cnt_reg == '0) state_reg <= CRC;
                    else               cnt_reg   <= cnt_reg - 15'd1;
                end
                CRC: begin
                    hs_req <= 1'b1;
                    tx_vld <= 1'b1;
`ifdef CSI_TX_CRC_EN
                    tx_dat <= crc_reg;
`else
                    tx_dat <= 16'h0000;
`endif
                    state_reg <= TRAIL;
                    cnt_reg   <= TRAIL_LOAD;
                end
                TRAIL: begin
                    // tx_dat still holds the last data word on the first trail cycle.
                    hs_req <= 1'b1;
                    tx_vld <= 1'b1;
                    if (cnt_reg == TRAIL_LOAD)
                        tx_dat <= {tx_dat[15] ? 8'h00 : 8'hFF, tx_dat[7] ? 8'h00 : 8'hFF};
                    if (cnt_reg == '0) begin
                        state_reg <= GAP;
                        cnt_reg   <= GAP_FULL;
                    end else begin
                        cnt_reg <= cnt_reg - 15'd1;
                    end
                end
                GAP: begin
                    tx_dat <= '0;
                    if (cnt_reg == '0) begin
                        state_reg <= IDLE;
                        cmd_ready <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 15'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csi_tx_packetizer.sv
// Table-driven bench for csi_tx_packetizer with a tx-word scoreboard queue.
module tb_csi_tx_packetizer;
    localparam int PREP_CYC  = 4;
    localparam int TRAIL_CYC = 2;
    localparam int GAP_CYC   = 8;

    logic        byte_clock = 1'b0;
    logic        reset_n    = 1'b0;
    logic        cmd_valid  = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_vc     = '0;
    logic [5:0]  cmd_dt     = '0;
    logic [15:0] cmd_wc     = '0;
    logic [15:0] pix_dat    = '0;
    logic        pix_vld    = 1'b0;
    logic        pix_rdy;
    logic        hs_req;
    logic [15:0] tx_dat;
    logic        tx_vld;
    logic        err_underflow;
    logic        err_wc;

    always #5 byte_clock = ~byte_clock;

    csi_tx_packetizer #(.PREP_CYC(PREP_CYC), .TRAIL_CYC(TRAIL_CYC), .GAP_CYC(GAP_CYC)) dut (
        .byte_clock(byte_clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_vc(cmd_vc), .cmd_dt(cmd_dt), .cmd_wc(cmd_wc),
        .pix_dat(pix_dat), .pix_vld(pix_vld), .pix_rdy(pix_rdy),
        .hs_req(hs_req), .tx_dat(tx_dat), .tx_vld(tx_vld),
        .err_underflow(err_underflow), .err_wc(err_wc)
    );

    typedef struct {
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
        int          uf_idx;
        bit          example;
        bit          ftr_fixed;
        logic [15:0] exp_hdr0;
        logic [15:0] exp_hdr1;
        logic [15:0] exp_ftr;
    } vec_t;

    vec_t        tbl [6];
    logic [15:0] ex_words [12] = '{16'h00FF, 16'h0200, 16'hDCB9, 16'h72F3, 16'hD4BB, 16'h5AB8,
                                   16'h75C8, 16'h7CC2, 16'hF881, 16'hDF05, 16'h00FF, 16'h0100};
    logic [15:0] exp_q [$];
    logic [15:0] pay_q [$];
    int n_cmp = 0;
    int n_bad = 0;
    int tx_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 16'h8408;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Scoreboard: every valid lane word is checked against the next queued expectation.
    always @(negedge byte_clock) begin
        if (tx_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tx_extra: got %h, required no word", tx_dat);
            end else begin
                check($sformatf("tx_word%0d", tx_idx), tx_dat, exp_q.pop_front());
            end
            tx_idx++;
        end
    end

    task automatic send_cmd(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
        int k;
        @(negedge byte_clock);
        cmd_vc = vc; cmd_dt = dt; cmd_wc = wc; cmd_valid = 1'b1;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 100) begin
            @(negedge byte_clock);
            k++;
        end
        check("cmd_ready_wait", cmd_ready, 1'b1);
        @(posedge byte_clock);
        @(negedge byte_clock);
        cmd_valid = 1'b0;
    endtask

    task automatic run_packet(input int idx, input int abort_at);
        vec_t v;
        logic [15:0] w, wt, crc, last, ftr;
        int n, pix_cnt, cyc, gap;
        bit long_pkt, prep_ok;
        v = tbl[idx];
        long_pkt = (v.dt >= 6'h10);
        n = long_pkt ? int'(v.wc) / 2 : 0;
        pay_q.delete();
        exp_q.delete();
        crc = 16'hFFFF;
        exp_q.push_back(16'hB8B8);
        exp_q.push_back(v.exp_hdr0);
        exp_q.push_back(v.exp_hdr1);
        last = v.exp_hdr1;
        for (int i = 0; i < n; i++) begin
            w = v.example ? ex_words[i] : 16'($urandom);
            pay_q.push_back(w);
            wt = (i == v.uf_idx) ? 16'h0000 : w;
            exp_q.push_back(wt);
            crc = crc_byte(crc_byte(crc, wt[7:0]), wt[15:8]);
        end
        if (long_pkt) begin
`ifdef CSI_TX_CRC_EN
            ftr = v.ftr_fixed ? v.exp_ftr : crc;
`else
            ftr = 16'h0000;
`endif
            exp_q.push_back(ftr);
            last = ftr;
        end
        for (int i = 0; i < TRAIL_CYC; i++)
            exp_q.push_back({last[15] ? 8'h00 : 8'hFF, last[7] ? 8'h00 : 8'hFF});

        send_cmd(v.vc, v.dt, v.wc);
        check($sformatf("pkt%0d_hs_rise", idx), hs_req, 1'b1);
        prep_ok = 1'b1;
        for (int p = 0; p < PREP_CYC; p++) begin
            if (hs_req !== 1'b1 || tx_vld !== 1'b0) prep_ok = 1'b0;
            @(negedge byte_clock);
        end
        check($sformatf("pkt%0d_prep", idx), prep_ok, 1'b1);
        check($sformatf("pkt%0d_sync_vld", idx), tx_vld, 1'b1);

        pix_cnt = 0;
        cyc = 0;
        while (hs_req === 1'b1 && cyc < 40000) begin
            if (abort_at >= 0 && pix_cnt == abort_at) begin
                #2 reset_n = 1'b0;
                #1;
                check("abort_hs_req", hs_req, 1'b0);
                check("abort_tx_vld", tx_vld, 1'b0);
                check("abort_pix_rdy", pix_rdy, 1'b0);
                pix_vld = 1'b0;
                exp_q.delete();
                @(negedge byte_clock);
                reset_n = 1'b1;
                @(negedge byte_clock);
                check("rel_cmd_ready", cmd_ready, 1'b1);
                check("rel_flags", {err_underflow, err_wc}, 2'b00);
                return;
            end
            if (pix_rdy === 1'b1) begin
                pix_dat = (pay_q.size() > 0) ? pay_q.pop_front() : 16'h0000;
                pix_vld = (pix_cnt != v.uf_idx);
                pix_cnt++;
            end else begin
                pix_vld = 1'b0;
            end
            @(negedge byte_clock);
            cyc++;
        end
        pix_vld = 1'b0;
        check($sformatf("pkt%0d_burst_end", idx), cyc < 40000, 1'b1);
        check($sformatf("pkt%0d_tx_vld_fall", idx), tx_vld, 1'b0);
        check($sformatf("pkt%0d_pix_rdy_cnt", idx), pix_cnt, n);
        gap = 0;
        while (cmd_ready !== 1'b1 && gap < 300) begin
            if (hs_req !== 1'b0) gap = 1000;
            gap++;
            @(negedge byte_clock);
        end
        check($sformatf("pkt%0d_gap", idx), gap, GAP_CYC);
        check($sformatf("pkt%0d_words_left", idx), exp_q.size(), 0);
        check($sformatf("pkt%0d_err_uf", idx), err_underflow, idx >= 3);
    endtask

    initial begin
        int low;
        bit hs_seen;
        tbl[0] = '{2'd0, 6'h00, 16'h0001, -1, 1'b0, 1'b0, 16'h0100, 16'h1A00, 16'h0000};
        tbl[1] = '{2'd0, 6'h2B, 16'd24,   -1, 1'b1, 1'b1, 16'h182B, 16'h1400, 16'h00F0};
        tbl[2] = '{2'd0, 6'h2B, 16'd0,    -1, 1'b0, 1'b1, 16'h002B, 16'h1700, 16'hFFFF};
        tbl[3] = '{2'd0, 6'h2B, 16'd16,    2, 1'b0, 1'b0, 16'h102B, 16'h3100, 16'h0000};
        tbl[4] = '{2'd1, 6'h01, 16'h0001, -1, 1'b0, 1'b0, 16'h0141, 16'h0B00, 16'h0000};
        tbl[5] = '{2'd2, 6'h1E, 16'd6,    -1, 1'b0, 1'b0, 16'h069E, 16'h3D00, 16'h0000};

        repeat (3) @(negedge byte_clock);
        check("rst_outputs", {cmd_ready, pix_rdy, hs_req, tx_vld, err_underflow, err_wc}, 6'b0);
        check("rst_tx_dat", tx_dat, 16'h0000);
        reset_n = 1'b1;
        @(negedge byte_clock);
        check("rst_cmd_ready", cmd_ready, 1'b1);

        for (int i = 0; i < 6; i++) run_packet(i, -1);
        check("err_wc_clear", err_wc, 1'b0);

        send_cmd(2'd0, 6'h2B, 16'd5);
        low = 1;
        hs_seen = 1'b0;
        while (cmd_ready !== 1'b1 && low < 300) begin
            if (hs_req !== 1'b0 || tx_vld !== 1'b0) hs_seen = 1'b1;
            low++;
            @(negedge byte_clock);
        end
        check("oddwc_err", err_wc, 1'b1);
        check("oddwc_no_hs", hs_seen, 1'b0);
        check("oddwc_gap", low - 1, GAP_CYC);

        run_packet(1, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
